// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TICK_W_DEF = cnt_w(OVERSAMPLE_DEF);
  localparam int BIT_W_DEF  = cnt_w(DATA_BITS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational: on contention the
// requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  always_comb begin
    idx_o = 1'b0;
    gnt_o = 2'b00;
    if (valid_i == 2'b11) begin
      idx_o = ~last_i;
    end else begin
      idx_o = valid_i[1];
    end
    if (valid_i != 2'b00) begin
      gnt_o = idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART TX scheduler: round-robin byte intake from two requesters, framed onto txd
// at one bit per OVERSAMPLE ticks; ready only in IDLE. Parity via UART_TX_PARITY_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int TW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  state_t               state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 grant_q;
  logic                 last_q;
  logic                 en_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  logic [1:0]           gnt;
  logic                 gnt_idx;
  logic                 rdy_en;
  logic                 accept;
  logic [DATA_BITS-1:0] acc_dat;
  logic [DATA_BITS-1:0] shift_nx;

  rr_arb2 u_arb (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx)
  );

  // en_q keeps ready low while reset is asserted and for its release cycle.
  assign rdy_en     = en_q && (state_q == IDLE);
  assign req0_ready = rdy_en & gnt[0];
  assign req1_ready = rdy_en & gnt[1];
  assign accept     = req0_ready | req1_ready;
  assign acc_dat    = gnt_idx ? req1_data : req0_data;
  assign shift_nx   = shift_q >> 1;

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      en_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      en_q <= 1'b1;
      if (state_q == IDLE) begin
        if (accept) begin
          shift_q    <= acc_dat;
          grant_q    <= gnt_idx;
          last_q     <= gnt_idx;
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          txd_q      <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= START;
`ifdef UART_TX_PARITY_EN
          par_q      <= ^acc_dat;
`endif
        end
      end else if (tick) begin
        if (tick_cnt_q != TICK_LAST) begin
          tick_cnt_q <= tick_cnt_q + 1'b1;
        end else begin
          // Bit boundary: txd takes the value of the next bit.
          tick_cnt_q <= '0;
          case (state_q)
            START: begin
              state_q <= DATA;
              txd_q   <= shift_q[0];
            end
            DATA: begin
              shift_q <= shift_nx;
              if (bit_cnt_q == DATA_LAST) begin
                bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                state_q   <= PARITY;
                txd_q     <= par_q;
`else
                state_q   <= STOP;
                txd_q     <= 1'b1;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                txd_q     <= shift_nx[0];
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end
`endif
            STOP: begin
              if (bit_cnt_q == STOP_LAST) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            default: begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a tick every 4 clocks (64 clocks per bit).
// Frame bits are sampled mid-bit against a bench-built expected frame.
module tb_uart_tx_sched;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       txd, busy, grant_id;

  int total = 0;
  int bad   = 0;
  int rdy0_n = 0;
  int rdy1_n = 0;
  bit tick_en = 1'b1;
  int div = 0;

  uart_tx_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .txd        (txd),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  // Tick generator: one pulse every 4 clocks; freezing tick_en freezes the phase.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        tick = (div == 3);
        div  = (div + 1) % 4;
      end else begin
        tick = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
`ifdef UART_TX_PARITY_EN
    b[9]   = ^d;
`endif
    return b;
  endfunction

  // Return at negedge+1 with tick high, so an acceptance lands on an ignored tick.
  task automatic align_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (tick !== 1'b1 && n < 16);
  endtask

  task automatic wait_accept(input logic exp_id, input string tag);
    bit got;
    got = 1'b0;
    #1;
    for (int n = 0; n < 3000; n++) begin
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk({tag, " accepted"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " ready id"}, 32'(req1_ready), 32'(exp_id));
      chk({tag, " one ready"}, 32'(req0_ready & req1_ready), 32'd0);
      chk({tag, " idle txd"}, 32'(txd), 32'd1);
      chk({tag, " idle busy"}, 32'(busy), 32'd0);
      if (req0_ready) rdy0_n++;
      else rdy1_n++;
      @(posedge clk); #1;
      chk({tag, " grant_id"}, 32'(grant_id), 32'(exp_id));
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit aligned, input int stall_len,
                           input string tag);
    logic [15:0] b;
    int len, nbusy, nrdy, stall_bad, s;
    b = frame_bits(d);
    len = (aligned ? NB * 64 : NB * 64 - 4) + stall_len;
    nbusy = 0; nrdy = 0; stall_bad = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk); #1;
      if (stall_len > 0 && i == 20) tick_en = 1'b0;
      if (stall_len > 0 && i == 20 + stall_len) tick_en = 1'b1;
      if (busy === 1'b1) nbusy++;
      if (req0_ready || req1_ready) nrdy++;
      if (stall_len > 0 && i > 20 && i < 20 + stall_len && txd !== 1'b0) stall_bad++;
      for (int k = 0; k < NB; k++) begin
        s = 32 + 64 * k + ((k >= 1) ? stall_len : 0);
        if (i == s) chk($sformatf("%s bit%0d", tag, k), 32'(txd), 32'(b[k]));
      end
    end
    chk({tag, " busy cycles"}, nbusy, len);
    chk({tag, " no ready mid-frame"}, nrdy, 0);
    if (stall_len > 0) chk({tag, " txd held in stall"}, stall_bad, 0);
    if (aligned) begin
      @(negedge clk); #1;
      chk({tag, " end busy"}, 32'(busy), 32'd0);
      chk({tag, " end txd"}, 32'(txd), 32'd1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, " idle reached"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset txd", 32'(txd), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready0", 32'(req0_ready), 32'd0);
    chk("reset ready1", 32'(req1_ready), 32'd0);
    chk("reset grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post-reset idle txd", 32'(txd), 32'd1);

    // Simultaneous requests: requester 0 first, then 1 after an idle-high clock.
    align_tick();
    req0_data = 8'hA3; req1_data = 8'h3C;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_accept(1'b0, "sim0");
    req0_valid = 1'b0;
    run_frame(8'hA3, 1'b1, 0, "sim0");
    wait_accept(1'b1, "sim1");
    req1_valid = 1'b0;
    run_frame(8'h3C, 1'b0, 0, "sim1");
    wait_idle("sim1");

    // Fairness with both requesters continuously valid.
    rdy0_n = 0; rdy1_n = 0;
    req0_data = 8'h0F; req1_data = 8'hF0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_accept(1'(f % 2), $sformatf("fair%0d", f));
      if (f == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      run_frame((f % 2) ? 8'hF0 : 8'h0F, 1'b0, 0, $sformatf("fair%0d", f));
    end
    wait_idle("fair");
    chk("fair ready0 pulses", rdy0_n, 2);
    chk("fair ready1 pulses", rdy1_n, 2);

    // Single request with exact frame length.
    align_tick();
    req0_data = 8'h55; req0_valid = 1'b1;
    wait_accept(1'b0, "single");
    req0_valid = 1'b0;
    run_frame(8'h55, 1'b1, 0, "single");

    // Tick stall of 500 clocks inside the start bit.
    align_tick();
    req1_data = 8'h81; req1_valid = 1'b1;
    wait_accept(1'b1, "stall");
    req1_valid = 1'b0;
    run_frame(8'h81, 1'b1, 500, "stall");

`ifdef UART_TX_PARITY_EN
    align_tick();
    req0_data = 8'h07; req0_valid = 1'b1;
    wait_accept(1'b0, "par");
    req0_valid = 1'b0;
    run_frame(8'h07, 1'b1, 0, "par");
`endif

    // Reset in the middle of data bit 3, with requester 1 pending.
    align_tick();
    req0_data = 8'hC6; req0_valid = 1'b1;
    wait_accept(1'b0, "rstmid");
    req0_valid = 1'b0;
    req1_data = 8'h5A; req1_valid = 1'b1;
    repeat (288) @(negedge clk);
    #1;
    chk("rstmid data bit3", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid txd", 32'(txd), 32'd1);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid ready1", 32'(req1_ready), 32'd0);
    chk("rstmid grant_id", 32'(grant_id), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid ready1 held", 32'(req1_ready), 32'd0);
    rst_n = 1'b1;
    wait_accept(1'b1, "after rst");
    req1_valid = 1'b0;
    run_frame(8'h5A, 1'b0, 0, "after rst");
    wait_idle("after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
